// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: the decode/EX/MEM observations the controller
// needs and the pipe-register controls and status it returns.
interface pipeline_hazard_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             mem_branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             ifid_write;
  logic             pipe_hold;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: reports what sits in ID/EX/MEM, obeys the controls
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
    input  pc_write, ifid_write, pipe_hold, idex_bubble,
           flush_ifid, flush_idex, flush_exmem,
           state, mem_timeout, stall_cycles, flush_count
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
    output pc_write, ifid_write, pipe_hold, idex_bubble,
           flush_ifid, flush_idex, flush_exmem,
           state, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and whole-pipe freezes while data memory is busy. Controls are Mealy
// outputs of the current state and inputs; counters and the timeout flag are
// registered status.
module pipeline_hazard_controller #(
  parameter int REG_W            = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hzIf
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [1:0]        LU_INIT  = 2'(LOAD_USE_BUBBLES - 1);
  localparam logic [REG_W-1:0]  ZERO_REG = '0;

  state_t            state_q, state_d;
  state_t            retState_q, retState_d;
  state_t            effState;
  logic [1:0]        luLeft_q, luLeft_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              memTimeout_q, memTimeout_d;
  logic [CNT_W-1:0]  stallCycles_q, stallCycles_d;
  logic [CNT_W-1:0]  flushCount_q, flushCount_d;
  logic              stallInc, flushInc;
  logic              hazard;

  logic pcWrite, ifidWrite, pipeHold, idexBubble;
  logic flushIfid, flushIdex, flushExmem;

  // Load-use hazard: a load in EX writes a register the ID instruction reads
  always_comb begin
    hazard = hzIf.ex_memread && (hzIf.ex_rt != ZERO_REG) &&
             ((hzIf.ex_rt == hzIf.id_rs) ||
              (hzIf.id_uses_rt && (hzIf.ex_rt == hzIf.id_rt)));
  end

  // Once memory releases, MEM_WAIT acts as whichever state it interrupted
  always_comb begin
    effState = (state_q == MEM_WAIT) ? retState_q : state_q;
  end

  // Next-state and control outputs, in priority reset > busy > branch > hazard
  always_comb begin
    state_d      = state_q;
    retState_d   = retState_q;
    luLeft_d     = luLeft_q;
    waitCnt_d    = waitCnt_q;
    memTimeout_d = memTimeout_q;
    stallInc     = 1'b0;
    flushInc     = 1'b0;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    pipeHold     = 1'b0;
    idexBubble   = 1'b0;
    flushIfid    = 1'b0;
    flushIdex    = 1'b0;
    flushExmem   = 1'b0;

    if (reset) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else if (hzIf.mem_busy) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      pipeHold  = 1'b1;
      stallInc  = 1'b1;
      if (state_q != MEM_WAIT) begin
        retState_d = state_q;
      end
      state_d = MEM_WAIT;
      if (waitCnt_q != WAIT_MAX) begin
        waitCnt_d = waitCnt_q + 1'b1;
      end
      if (waitCnt_q >= WAIT_MAX - 1'b1) begin
        memTimeout_d = 1'b1;
      end
    end else begin
      waitCnt_d = '0;
      state_d   = RUN;
      if (hzIf.mem_branch_taken) begin
        flushIfid  = 1'b1;
        flushIdex  = 1'b1;
        flushExmem = 1'b1;
        luLeft_d   = 2'd0;
        flushInc   = 1'b1;
      end else if (effState == LU_STALL) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        stallInc   = 1'b1;
        luLeft_d   = luLeft_q - 1'b1;
        state_d    = (luLeft_q == 2'd1) ? RUN : LU_STALL;
      end else if (hazard) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        stallInc   = 1'b1;
        if (LOAD_USE_BUBBLES > 1) begin
          luLeft_d = LU_INIT;
          state_d  = LU_STALL;
        end
      end
    end
  end

  // Performance counters stick at all-ones instead of wrapping
  always_comb begin
    stallCycles_d = stallCycles_q;
    flushCount_d  = flushCount_q;
    if (stallInc && (stallCycles_q != {CNT_W{1'b1}})) begin
      stallCycles_d = stallCycles_q + 1'b1;
    end
    if (flushInc && (flushCount_q != {CNT_W{1'b1}})) begin
      flushCount_d = flushCount_q + 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      retState_q    <= RUN;
      luLeft_q      <= 2'd0;
      waitCnt_q     <= '0;
      memTimeout_q  <= 1'b0;
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      retState_q    <= retState_d;
      luLeft_q      <= luLeft_d;
      waitCnt_q     <= waitCnt_d;
      memTimeout_q  <= memTimeout_d;
      stallCycles_q <= stallCycles_d;
      flushCount_q  <= flushCount_d;
    end
  end

  assign hzIf.pc_write     = pcWrite;
  assign hzIf.ifid_write   = ifidWrite;
  assign hzIf.pipe_hold    = pipeHold;
  assign hzIf.idex_bubble  = idexBubble;
  assign hzIf.flush_ifid   = flushIfid;
  assign hzIf.flush_idex   = flushIdex;
  assign hzIf.flush_exmem  = flushExmem;
  assign hzIf.state        = state_q;
  assign hzIf.mem_timeout  = memTimeout_q;
  assign hzIf.stall_cycles = stallCycles_q;
  assign hzIf.flush_count  = flushCount_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed hazard scenarios
// followed by random traffic, checked against a bubble-budget reference model.
module tb_pipeline_hazard_controller;

  localparam int REG_W = 5;
  localparam int LUB   = 2;
  localparam int MT    = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [6:0]       ctrl;
    logic [1:0]       st;
    logic             tmo;
    logic [CNT_W-1:0] stalls;
    logic [CNT_W-1:0] flushes;
  } exp_t;

  logic clk;
  logic reset;
  exp_t expQ[$];
  int   nCompared;
  int   nMismatched;

  // Reference model: a frozen flag, remaining bubbles owed, busy run length
  bit mInWait;
  int mPending;
  int mBusyRun;
  bit mTimeout;
  int mStalls;
  int mFlushes;

  pipeline_hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hzIf();

  pipeline_hazard_controller #(
    .REG_W(REG_W), .LOAD_USE_BUBBLES(LUB), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hzIf(hzIf)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for that cycle
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic memRd, input logic [4:0] exRt,
                               input logic br, input logic busy);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    reset                 = rst;
    hzIf.id_rs            = rs;
    hzIf.id_rt            = rt;
    hzIf.id_uses_rt       = usesRt;
    hzIf.ex_memread       = memRd;
    hzIf.ex_rt            = exRt;
    hzIf.mem_branch_taken = br;
    hzIf.mem_busy         = busy;

    hz = memRd && (exRt != 0) && ((exRt == rs) || (usesRt && (exRt == rt)));

    e.st      = mInWait ? 2'd2 : ((mPending > 0) ? 2'd1 : 2'd0);
    e.tmo     = mTimeout;
    e.stalls  = CNT_W'(mStalls);
    e.flushes = CNT_W'(mFlushes);

    // ctrl = {pc_write, ifid_write, pipe_hold, idex_bubble, flush_ifid, flush_idex, flush_exmem}
    if (rst) begin
      e.ctrl   = 7'b0000000;
      mInWait  = 0;
      mPending = 0;
      mBusyRun = 0;
      mTimeout = 0;
      mStalls  = 0;
      mFlushes = 0;
    end else if (busy) begin
      e.ctrl  = 7'b0010000;
      mInWait = 1;
      if (mBusyRun < MT) mBusyRun++;
      if (mBusyRun == MT) mTimeout = 1;
      if (mStalls < MAXC) mStalls++;
    end else begin
      mInWait  = 0;
      mBusyRun = 0;
      if (br) begin
        e.ctrl   = 7'b1100111;
        mPending = 0;
        if (mFlushes < MAXC) mFlushes++;
      end else if (mPending > 0) begin
        e.ctrl = 7'b0001000;
        mPending--;
        if (mStalls < MAXC) mStalls++;
      end else if (hz) begin
        e.ctrl   = 7'b0001000;
        mPending = LUB - 1;
        if (mStalls < MAXC) mStalls++;
      end else begin
        e.ctrl = 7'b1100000;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  // Monitor: pop one prediction per cycle and compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("ctrl", 32'({hzIf.pc_write, hzIf.ifid_write, hzIf.pipe_hold, hzIf.idex_bubble,
                                 hzIf.flush_ifid, hzIf.flush_idex, hzIf.flush_exmem}), 32'(e.ctrl));
        checkOutput("state", 32'(hzIf.state), 32'(e.st));
        checkOutput("mem_timeout", 32'(hzIf.mem_timeout), 32'(e.tmo));
        checkOutput("stall_cycles", 32'(hzIf.stall_cycles), 32'(e.stalls));
        checkOutput("flush_count", 32'(hzIf.flush_count), 32'(e.flushes));
      end
    end
  end

  // Stimulus: directed scenarios, then random traffic
  initial begin
    logic       rst, usesRt, memRd, br, busy;
    logic [4:0] rs, rt, exRt;
    int         burst;

    nCompared   = 0;
    nMismatched = 0;
    reset                 = 1'b1;
    hzIf.id_rs            = '0;
    hzIf.id_rt            = '0;
    hzIf.id_uses_rt       = 1'b0;
    hzIf.ex_memread       = 1'b0;
    hzIf.ex_rt            = '0;
    hzIf.mem_branch_taken = 1'b0;
    hzIf.mem_busy         = 1'b0;
    repeat (2) @(posedge clk);
    mInWait = 0; mPending = 0; mBusyRun = 0; mTimeout = 0; mStalls = 0; mFlushes = 0;

    $display("[TB] directed scenarios");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    // load-use on rs
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
    idle(2);
    // r0 never hazards; rt matters only when it is read
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(2);
    // memory busy long enough to time out
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);
    // hazard and taken branch together: flush wins
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    idle(2);
    // hazard, then freeze inside the load-use stall
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1);
    idle(3);
    // reset in the middle of a freeze
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] random traffic");
    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 99) < 15) begin
        busy = 1'b1;
        if ($urandom_range(0, 9) == 0) burst = $urandom_range(3, 7);
      end else begin
        busy = 1'b0;
      end
      br     = ($urandom_range(0, 99) < 10);
      memRd  = 1'($urandom_range(0, 1));
      usesRt = 1'($urandom_range(0, 1));
      exRt   = pickReg();
      rs     = pickReg();
      rt     = pickReg();
      applyStimulus(rst, rs, rt, usesRt, memRd, exRt, br, busy);
    end

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
